mips_multicycle_core: RTL and testbench

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

---
 rtl/mips_pkg.sv | 35 +++
 rtl/mips_regfile.sv | 47 ++++
 rtl/mips_multicycle_core.sv | 204 ++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcode/funct constants,
// FSM state encoding and the ALU operation enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

endpackage

// File: rtl/mips_regfile.sv
// 2-read / 1-write register file; R0 reads as zero and ignores writes.
// With MIPS_CORE_DEBUG_TAP_EN defined a third combinational read port is added.
module mips_regfile #(
    parameter int DW  = 8,
    parameter int RAW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [RAW-1:0] ra1,
    input  logic [RAW-1:0] ra2,
    output logic [DW-1:0]  rd1,
    output logic [DW-1:0]  rd2,
    input  logic           we,
    input  logic [RAW-1:0] wa,
    input  logic [DW-1:0]  wd
`ifdef MIPS_CORE_DEBUG_TAP_EN
    ,
    input  logic [RAW-1:0] dbg_sel,
    output logic [DW-1:0]  dbg_data
`endif
);

    localparam int NREG = 2 ** RAW;

    logic [NREG-1:0][DW-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != '0))
            regs_d[wa] = wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs_q <= '0;
        else
            regs_q <= regs_d;
    end

    assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];

`ifdef MIPS_CORE_DEBUG_TAP_EN
    assign dbg_data = (dbg_sel == '0) ? '0 : regs_q[dbg_sel];
`endif

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB FSM with ALU inline.
// Optional MIPS_CORE_DEBUG_TAP_EN adds dbg_sel/dbg_data register display taps.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int DW  = 8,
    parameter int RAW = 3,
    parameter int IAW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           imem_req,
    output logic [IAW-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [31:0]    imem_data,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [DW-1:0]  dmem_addr,
    output logic [DW-1:0]  dmem_wdata,
    input  logic           dmem_ack,
    input  logic [DW-1:0]  dmem_rdata,
    output logic [IAW-1:0] pc_o,
    output logic [2:0]     state_o,
    output logic           halt_o
`ifdef MIPS_CORE_DEBUG_TAP_EN
    ,
    input  logic [RAW-1:0] dbg_sel,
    output logic [DW-1:0]  dbg_data
`endif
);

    state_e          state_q, state_d;
    logic [IAW-1:0]  pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [DW-1:0]   res_q, res_d;

    logic [5:0]      op, funct;
    logic [DW-1:0]   imm;
    logic [IAW-1:0]  br_off;
    logic [DW-1:0]   rd1, rd2;
    alu_op_e         alu_op;
    logic [DW-1:0]   alu_b, alu_y;
    logic            op_ok;
    logic            rf_we;
    logic [RAW-1:0]  rf_wa;
    logic            unused_ir;

    assign op        = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign unused_ir = ^ir_q;

    if (DW > 16) begin : g_imm_sx
        assign imm = {{(DW-16){ir_q[15]}}, ir_q[15:0]};
    end else begin : g_imm_tr
        assign imm = ir_q[DW-1:0];
    end

    // Branch offset sized to the PC so the add wraps modulo 2**IAW.
    if (IAW > 16) begin : g_br_sx
        assign br_off = {{(IAW-16){ir_q[15]}}, ir_q[15:0]};
    end else begin : g_br_tr
        assign br_off = ir_q[IAW-1:0];
    end

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = b_q;
        op_ok  = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: op_ok  = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_b = imm;
            OP_BEQ, OP_J: ;
            default: op_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD: alu_y = a_q + alu_b;
            ALU_SUB: alu_y = a_q - alu_b;
            ALU_AND: alu_y = a_q & alu_b;
            ALU_OR:  alu_y = a_q | alu_b;
            ALU_SLT: alu_y = {{(DW-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            S_FETCH: begin
                if (imem_req && imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rd1;
                b_d     = rd2;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d = alu_y;
                if (!op_ok) begin
                    state_d = S_HALT;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_d = S_MEM;
                        OP_BEQ: begin
                            if (a_q == b_q)
                                pc_d = pc_q + br_off;
                            state_d = S_FETCH;
                        end
                        OP_J: begin
                            pc_d    = ir_q[IAW-1:0];
                            state_d = S_FETCH;
                        end
                        default: state_d = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                if (dmem_req && dmem_ack) begin
                    if (op == OP_LW) begin
                        res_d   = dmem_rdata;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Requests are gated by rst_n so they drop the instant reset asserts.
    assign imem_req   = rst_n && (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = rst_n && (state_q == S_MEM);
    assign dmem_we    = dmem_req && (op == OP_SW);
    assign dmem_addr  = res_q;
    assign dmem_wdata = b_q;
    assign pc_o       = pc_q;
    assign state_o    = state_q;
    assign halt_o     = (state_q == S_HALT);

    assign rf_we = (state_q == S_WB);
    assign rf_wa = (op == OP_RTYPE) ? ir_q[11 +: RAW] : ir_q[16 +: RAW];

    mips_regfile #(.DW(DW), .RAW(RAW)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (ir_q[21 +: RAW]),
        .ra2      (ir_q[16 +: RAW]),
        .rd1      (rd1),
        .rd2      (rd2),
        .we       (rf_we),
        .wa       (rf_wa),
        .wd       (res_q)
`ifdef MIPS_CORE_DEBUG_TAP_EN
        ,
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
`endif
    );

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small programs in a modelled imem,
// register results observed through stores into a modelled dmem.
module tb_mips_multicycle_core;
    import mips_pkg::*;

    localparam int DW = 8, RAW = 3, IAW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halt_o;
    logic [IAW-1:0] imem_addr, pc_o;
    logic [31:0]    imem_data;
    logic [DW-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic [2:0]     state_o;

    int checks = 0, errors = 0;
    int i_dly = 0, d_dly = 0, i_cnt = 0, d_cnt = 0;
    bit dclr = 1'b0;
    logic [31:0] imem [256];
    logic [7:0]  dmem [256];

    always #5 clk = ~clk;

    mips_multicycle_core #(.DW(DW), .RAW(RAW), .IAW(IAW)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_o(pc_o), .state_o(state_o), .halt_o(halt_o)
    );

    assign imem_ack   = imem_req && (i_cnt >= i_dly);
    assign imem_data  = imem[imem_addr];
    assign dmem_ack   = dmem_req && (d_cnt >= d_dly);
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        i_cnt <= (imem_req && !imem_ack) ? i_cnt + 1 : 0;
        d_cnt <= (dmem_req && !dmem_ack) ? d_cnt + 1 : 0;
        if (dclr) begin
            for (int k = 0; k < 256; k++) dmem[k] <= 8'h55;
        end else if (dmem_req && dmem_we && dmem_ack) begin
            dmem[dmem_addr] <= dmem_wdata;
        end
    end

    always @(negedge clk) begin
        if (imem_req && dmem_req) begin
            errors++;
            $display("FAIL req_overlap imem_req=%0b dmem_req=%0b exp no overlap", imem_req, dmem_req);
        end
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(input int addr);
        return {OP_J, 26'(addr)};
    endfunction

    task automatic load_clear();
        for (int k = 0; k < 256; k++) imem[k] = 32'hFC00_0000;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; dclr = 1'b1;
        @(negedge clk); dclr = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        load_clear();
        imem[0] = enc_i(OP_ADDI, 0, 1, 1);
        rst_n = 1'b0; dclr = 1'b1;
        @(negedge clk); #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req got %0b exp 0", imem_req); end
        checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL rst_dmem got req=%0b we=%0b exp 0", dmem_req, dmem_we); end
        checks++; if (pc_o !== 8'd0 || state_o !== 3'd0 || halt_o !== 1'b0) begin errors++; $display("FAIL rst_state pc=%0d st=%0d halt=%0b exp 0/0/0", pc_o, state_o, halt_o); end
        dclr = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin errors++; $display("FAIL rst_first_fetch req=%0b addr=%0d exp 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_alu();
        load_clear(); i_dly = 0; d_dly = 0;
        imem[0]  = enc_i(OP_ADDI, 0, 1, 5);
        imem[1]  = enc_i(OP_ADDI, 0, 2, 3);
        imem[2]  = enc_r(1, 2, 3, FN_ADD);
        imem[3]  = enc_i(OP_SW, 0, 3, 16);
        imem[4]  = enc_r(2, 1, 4, FN_SUB);
        imem[5]  = enc_i(OP_SW, 0, 4, 17);
        imem[6]  = enc_i(OP_ADDI, 0, 5, -2);
        imem[7]  = enc_i(OP_ADDI, 0, 6, 1);
        imem[8]  = enc_r(5, 6, 7, FN_SLT);
        imem[9]  = enc_i(OP_SW, 0, 7, 18);
        imem[10] = enc_i(OP_ADDI, 0, 0, 7);
        imem[11] = enc_i(OP_SW, 0, 0, 19);
        imem[12] = enc_r(1, 2, 3, FN_AND);
        imem[13] = enc_i(OP_SW, 0, 3, 20);
        imem[14] = enc_r(1, 2, 3, FN_OR);
        imem[15] = enc_i(OP_SW, 0, 3, 21);
        imem[16] = enc_r(6, 5, 7, FN_SLT);
        imem[17] = enc_i(OP_SW, 0, 7, 22);
        imem[18] = enc_j(18);
        do_reset();
        run(12);
        checks++; if (pc_o !== 8'd3 || state_o !== 3'd0) begin errors++; $display("FAIL alu_12cyc pc=%0d st=%0d exp 3/0", pc_o, state_o); end
        run(4);
        checks++; if (pc_o !== 8'd4 || state_o !== 3'd0) begin errors++; $display("FAIL sw_4cyc pc=%0d st=%0d exp 4/0", pc_o, state_o); end
        run(80);
        checks++; if (dmem[16] !== 8'h08) begin errors++; $display("FAIL add_3p5 got %h exp 08", dmem[16]); end
        checks++; if (dmem[17] !== 8'hFE) begin errors++; $display("FAIL sub_3m5 got %h exp fe", dmem[17]); end
        checks++; if (dmem[18] !== 8'h01) begin errors++; $display("FAIL slt_m2_lt_1 got %h exp 01", dmem[18]); end
        checks++; if (dmem[19] !== 8'h00) begin errors++; $display("FAIL r0_hardwired got %h exp 00", dmem[19]); end
        checks++; if (dmem[20] !== 8'h01) begin errors++; $display("FAIL and_5_3 got %h exp 01", dmem[20]); end
        checks++; if (dmem[21] !== 8'h07) begin errors++; $display("FAIL or_5_3 got %h exp 07", dmem[21]); end
        checks++; if (dmem[22] !== 8'h00) begin errors++; $display("FAIL slt_1_lt_m2 got %h exp 00", dmem[22]); end
        checks++; if (pc_o < 8'd18 || pc_o > 8'd19 || halt_o !== 1'b0) begin errors++; $display("FAIL alu_end pc=%0d halt=%0b exp 18..19/0", pc_o, halt_o); end
    endtask

    task automatic test_mem();
        load_clear(); i_dly = 0; d_dly = 2;
        imem[0] = enc_i(OP_ADDI, 0, 3, 8);
        imem[1] = enc_i(OP_SW, 0, 3, 2);
        imem[2] = enc_i(OP_LW, 0, 4, 2);
        imem[3] = enc_i(OP_SW, 0, 4, 3);
        imem[4] = enc_j(4);
        do_reset();
        run(7);
        checks++; if (state_o !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 8'd2 || dmem_wdata !== 8'd8) begin
            errors++; $display("FAIL sw_mem st=%0d req=%0b we=%0b addr=%0d wd=%0d exp 3/1/1/2/8", state_o, dmem_req, dmem_we, dmem_addr, dmem_wdata); end
        for (int c = 0; c < 2; c++) begin
            run(1);
            checks++; if (state_o !== 3'd3 || dmem_addr !== 8'd2 || dmem_wdata !== 8'd8) begin
                errors++; $display("FAIL sw_wait_hold st=%0d addr=%0d wd=%0d exp 3/2/8", state_o, dmem_addr, dmem_wdata); end
        end
        run(1);
        checks++; if (state_o !== 3'd0 || pc_o !== 8'd2 || dmem[2] !== 8'h08) begin
            errors++; $display("FAIL sw_done st=%0d pc=%0d mem=%h exp 0/2/08", state_o, pc_o, dmem[2]); end
        run(3);
        checks++; if (state_o !== 3'd3 || dmem_we !== 1'b0 || dmem_addr !== 8'd2) begin
            errors++; $display("FAIL lw_mem st=%0d we=%0b addr=%0d exp 3/0/2", state_o, dmem_we, dmem_addr); end
        run(3);
        checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL lw_wb st=%0d exp 4", state_o); end
        run(1);
        checks++; if (state_o !== 3'd0 || pc_o !== 8'd3) begin errors++; $display("FAIL lw_done st=%0d pc=%0d exp 0/3", state_o, pc_o); end
        run(20);
        checks++; if (dmem[3] !== 8'h08) begin errors++; $display("FAIL lw_value got %h exp 08", dmem[3]); end
    endtask

    task automatic test_branch();
        load_clear(); i_dly = 0; d_dly = 0;
        imem[0] = enc_i(OP_ADDI, 0, 1, 1);
        imem[1] = enc_i(OP_ADDI, 0, 0, 0);
        imem[2] = enc_i(OP_ADDI, 0, 0, 0);
        imem[3] = enc_i(OP_ADDI, 0, 0, 0);
        imem[4] = enc_i(OP_BEQ, 1, 1, -1);
        do_reset();
        run(16);
        checks++; if (pc_o !== 8'd4 || state_o !== 3'd0) begin errors++; $display("FAIL beq_reach pc=%0d st=%0d exp 4/0", pc_o, state_o); end
        for (int it = 0; it < 3; it++) begin
            run(1);
            checks++; if (pc_o !== 8'd5) begin errors++; $display("FAIL beq_inc pc=%0d exp 5", pc_o); end
            run(2);
            checks++; if (pc_o !== 8'd4 || state_o !== 3'd0 || imem_addr !== 8'd4) begin
                errors++; $display("FAIL beq_loop pc=%0d st=%0d addr=%0d exp 4/0/4", pc_o, state_o, imem_addr); end
        end
    endtask

    task automatic test_jump();
        load_clear(); i_dly = 0; d_dly = 0;
        imem[0]    = enc_j(8'h10);
        imem[8'h10] = enc_i(OP_ADDI, 0, 1, 1);
        imem[8'h11] = enc_i(OP_BEQ, 0, 1, 5);
        imem[8'h12] = enc_j(8'h12);
        do_reset();
        run(3);
        checks++; if (state_o !== 3'd0 || imem_addr !== 8'h10 || imem_req !== 1'b1) begin
            errors++; $display("FAIL j_target st=%0d addr=%h req=%0b exp 0/10/1", state_o, imem_addr, imem_req); end
        run(7);
        checks++; if (pc_o !== 8'h12 || state_o !== 3'd0) begin errors++; $display("FAIL beq_not_taken pc=%h st=%0d exp 12/0", pc_o, state_o); end
    endtask

    task automatic test_halt();
        int bad;
        load_clear(); i_dly = 0; d_dly = 0;
        imem[0] = {6'h3F, 26'h0};
        do_reset();
        run(3);
        checks++; if (state_o !== 3'd5 || halt_o !== 1'b1) begin errors++; $display("FAIL halt_op st=%0d halt=%0b exp 5/1", state_o, halt_o); end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            run(1);
            if (imem_req !== 1'b0 || dmem_req !== 1'b0 || state_o !== 3'd5) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL halt_hold bad_cycles=%0d exp 0", bad); end
        rst_n = 1'b0; #1;
        checks++; if (halt_o !== 1'b0 || state_o !== 3'd0) begin errors++; $display("FAIL halt_reset halt=%0b st=%0d exp 0/0", halt_o, state_o); end
        imem[0] = enc_r(1, 2, 3, 6'h3F);
        do_reset();
        run(3);
        checks++; if (state_o !== 3'd5 || halt_o !== 1'b1) begin errors++; $display("FAIL halt_funct st=%0d halt=%0b exp 5/1", state_o, halt_o); end
    endtask

    task automatic test_reset_mid();
        load_clear(); i_dly = 0; d_dly = 10;
        imem[0] = enc_i(OP_ADDI, 0, 3, 9);
        imem[1] = enc_i(OP_SW, 0, 3, 5);
        do_reset();
        run(7);
        checks++; if (state_o !== 3'd3 || dmem_req !== 1'b1) begin errors++; $display("FAIL mid_mem st=%0d req=%0b exp 3/1", state_o, dmem_req); end
        #2 rst_n = 1'b0; #1;
        checks++; if (dmem_req !== 1'b0 || pc_o !== 8'd0 || state_o !== 3'd0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL mid_rst dreq=%0b pc=%0d st=%0d ireq=%0b exp 0/0/0/0", dmem_req, pc_o, state_o, imem_req); end
        @(negedge clk); @(negedge clk);
        load_clear(); d_dly = 0;
        imem[0] = enc_i(OP_SW, 0, 3, 6);
        imem[1] = enc_j(1);
        rst_n = 1'b1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin errors++; $display("FAIL mid_release req=%0b addr=%0d exp 1/0", imem_req, imem_addr); end
        run(10);
        checks++; if (dmem[5] !== 8'h55) begin errors++; $display("FAIL mid_abandon mem5=%h exp 55", dmem[5]); end
        checks++; if (dmem[6] !== 8'h00) begin errors++; $display("FAIL mid_regs_cleared mem6=%h exp 00", dmem[6]); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_jump();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
